// File: rtl/dna_word_packer_if.sv
// Handshake bundle for dna_word_packer: serial digit input stream and packed word output stream.
// Optional out_gc member is present only when DNA_PACK_GC_EN is defined.
interface dna_word_packer_if #(
    parameter int unsigned N = 4
) ();
    localparam int unsigned CW = $clog2(N + 1);

    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_digit;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [2*N-1:0]  out_word;
    logic [CW-1:0]   out_count;
    logic            out_last;
`ifdef DNA_PACK_GC_EN
    logic [CW-1:0]   out_gc;
`endif

    // Packer side.
    modport slave (
        input  in_valid,
        input  in_digit,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_word,
        output out_count,
`ifdef DNA_PACK_GC_EN
        output out_gc,
`endif
        output out_last
    );

    // Producer/consumer side.
    modport master (
        output in_valid,
        output in_digit,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_word,
        input  out_count,
`ifdef DNA_PACK_GC_EN
        input  out_gc,
`endif
        input  out_last
    );
endinterface

// File: rtl/dna_word_packer.sv
// Packs a serial stream of 2-bit nucleotide digits MSB-first into N-digit words with
// padded end-of-sequence flush. Optional G/C count output enabled by DNA_PACK_GC_EN.
module dna_word_packer #(
    parameter int unsigned N         = 4,
    parameter logic [1:0]  PAD_DIGIT = 2'b00
) (
    input logic               clk,
    input logic               rst,
    dna_word_packer_if.slave  io_bus
);
    localparam int unsigned CW   = $clog2(N + 1);
    localparam int unsigned CNTW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNTW-1:0] CntMax = CNTW'(N - 1);

    logic [2*N-1:0]  r_acc;
    logic [CNTW-1:0] r_cnt;
    logic            r_out_valid;
    logic [2*N-1:0]  r_out_word;
    logic [CW-1:0]   r_out_count;
    logic            r_out_last;

    logic            w_in_ready;
    logic            w_accept;
    logic            w_complete;
    logic [2*N-1:0]  w_word;
    logic [CW-1:0]   w_count;
`ifdef DNA_PACK_GC_EN
    logic [CW-1:0]   w_gc;
    logic [CW-1:0]   r_out_gc;
`endif

    assign w_in_ready = !r_out_valid || io_bus.out_ready;
    assign w_accept   = io_bus.in_valid && w_in_ready;
    assign w_complete = w_accept && ((r_cnt == CntMax) || io_bus.in_last);
    assign w_count    = CW'(r_cnt) + CW'(1);

    // Word as it stands with the incoming digit inserted at slot r_cnt; later slots padded.
    always_comb begin
        w_word = '0;
        for (int k = 0; k < N; k++) begin
            if (CNTW'(k) < r_cnt) begin
                w_word[2*(N-1-k) +: 2] = r_acc[2*(N-1-k) +: 2];
            end else if (CNTW'(k) == r_cnt) begin
                w_word[2*(N-1-k) +: 2] = io_bus.in_digit;
            end else begin
                w_word[2*(N-1-k) +: 2] = PAD_DIGIT;
            end
        end
    end

`ifdef DNA_PACK_GC_EN
    // G and C codes both have the high bit set; pad slots lie beyond r_cnt and are skipped.
    always_comb begin
        w_gc = '0;
        for (int k = 0; k < N; k++) begin
            if ((CNTW'(k) <= r_cnt) && w_word[2*(N-1-k)+1]) begin
                w_gc = w_gc + CW'(1);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= {N{PAD_DIGIT}};
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_word  <= '0;
            r_out_count <= '0;
            r_out_last  <= 1'b0;
`ifdef DNA_PACK_GC_EN
            r_out_gc    <= '0;
`endif
        end else begin
            if (r_out_valid && io_bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            // A completing accept overrides the drain above and reloads the slot.
            if (w_accept) begin
                if (w_complete) begin
                    r_out_valid <= 1'b1;
                    r_out_word  <= w_word;
                    r_out_count <= w_count;
                    r_out_last  <= io_bus.in_last;
`ifdef DNA_PACK_GC_EN
                    r_out_gc    <= w_gc;
`endif
                    r_cnt       <= '0;
                    r_acc       <= {N{PAD_DIGIT}};
                end else begin
                    r_acc <= w_word;
                    r_cnt <= r_cnt + CNTW'(1);
                end
            end
        end
    end

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_word  = r_out_word;
    assign io_bus.out_count = r_out_count;
    assign io_bus.out_last  = r_out_last;
`ifdef DNA_PACK_GC_EN
    assign io_bus.out_gc    = r_out_gc;
`endif
endmodule

// File: tb/tb_dna_word_packer.sv
// Directed self-checking bench for dna_word_packer with N=4, PAD_DIGIT=00.
// G/C count checks are compiled in when DNA_PACK_GC_EN is defined.
module tb_dna_word_packer;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    dna_word_packer_if #(.N(4)) bus ();

    dna_word_packer #(
        .N         (4),
        .PAD_DIGIT (2'b00)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one digit for exactly one clock edge.
    task automatic send(input logic [1:0] dg, input logic lst);
        bus.in_valid = 1'b1;
        bus.in_digit = dg;
        bus.in_last  = lst;
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_digit  = 2'b00;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_word !== 8'h00 || bus.out_count !== 3'd0
            || bus.out_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b word=%b count=%0d last=%b expected all 0",
                     bus.out_valid, bus.out_word, bus.out_count, bus.out_last);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
`ifdef DNA_PACK_GC_EN
        checks++;
        if (bus.out_gc !== 3'd0) begin
            failures++;
            $display("FAIL reset_gc: got %0d expected 0", bus.out_gc);
        end
`endif
    endtask

    task automatic test_full_word();
        logic [1:0] d [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL full_in_ready[%0d]: got %b expected 1", i, bus.in_ready);
            end
            send(d[i], i == 3);
            if (i < 3) begin
                checks++;
                if (bus.out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL full_early_valid[%0d]: got %b expected 0", i, bus.out_valid);
                end
            end
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_word !== 8'b01101100 || bus.out_count !== 3'd4
            || bus.out_last !== 1'b1) begin
            failures++;
            $display("FAIL full_word: valid=%b word=%b count=%0d last=%b expected 1 01101100 4 1",
                     bus.out_valid, bus.out_word, bus.out_count, bus.out_last);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_valid_one_cycle: got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_partial_flush();
        bus.out_ready = 1'b1;
        send(2'b11, 1'b0);
        send(2'b10, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_word !== 8'b11100000 || bus.out_count !== 3'd2
            || bus.out_last !== 1'b1) begin
            failures++;
            $display("FAIL partial_word: valid=%b word=%b count=%0d last=%b expected 1 11100000 2 1",
                     bus.out_valid, bus.out_word, bus.out_count, bus.out_last);
        end
        send(2'b01, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_word !== 8'b01000000 || bus.out_count !== 3'd1
            || bus.out_last !== 1'b1) begin
            failures++;
            $display("FAIL partial_restart: valid=%b word=%b count=%0d last=%b expected 1 01000000 1 1",
                     bus.out_valid, bus.out_word, bus.out_count, bus.out_last);
        end
        step();
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, bus.in_ready);
            end
            bus.in_valid = 1'b1;
            bus.in_digit = 2'(i);
            bus.in_last  = 1'b0;
            step();
            if (i == 3 || i == 7) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_word !== 8'b00011011
                    || bus.out_count !== 3'd4 || bus.out_last !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_word[%0d]: valid=%b word=%b count=%0d last=%b expected 1 00011011 4 0",
                             i, bus.out_valid, bus.out_word, bus.out_count, bus.out_last);
                end
            end
        end
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] a [4] = '{2'b10, 2'b01, 2'b11, 2'b00};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(a[i], 1'b0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_digit  = 2'b11;
        bus.in_last   = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_word !== 8'b10011100 || bus.out_count !== 3'd4
                || bus.out_last !== 1'b0 || bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d]: valid=%b word=%b count=%0d last=%b in_ready=%b expected 1 10011100 4 0 0",
                         i, bus.out_valid, bus.out_word, bus.out_count, bus.out_last, bus.in_ready);
            end
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_ready: got %b expected 1", bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_word !== 8'b11000000 || bus.out_count !== 3'd1
            || bus.out_last !== 1'b1) begin
            failures++;
            $display("FAIL bp_reload: valid=%b word=%b count=%0d last=%b expected 1 11000000 1 1",
                     bus.out_valid, bus.out_word, bus.out_count, bus.out_last);
        end
        send(2'b01, 1'b0);
        send(2'b01, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_word !== 8'b01010000 || bus.out_count !== 3'd2) begin
            failures++;
            $display("FAIL bp_next_word: valid=%b word=%b count=%0d expected 1 01010000 2",
                     bus.out_valid, bus.out_word, bus.out_count);
        end
        step();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(2'b11, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_word !== 8'h00 || bus.out_count !== 3'd0
            || bus.out_last !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_outputs: valid=%b word=%b count=%0d last=%b in_ready=%b expected 0 0 0 0 1",
                     bus.out_valid, bus.out_word, bus.out_count, bus.out_last, bus.in_ready);
        end
        for (int i = 0; i < 4; i++) send(2'b10, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_word !== 8'b10101010 || bus.out_count !== 3'd4
            || bus.out_last !== 1'b0) begin
            failures++;
            $display("FAIL midreset_fresh: valid=%b word=%b count=%0d last=%b expected 1 10101010 4 0",
                     bus.out_valid, bus.out_word, bus.out_count, bus.out_last);
        end
        step();
        // Reset with a word held by backpressure.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(2'b01, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_word !== 8'h00 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL pendreset: valid=%b word=%b in_ready=%b expected 0 00000000 1",
                     bus.out_valid, bus.out_word, bus.in_ready);
        end
        bus.out_ready = 1'b1;
    endtask

`ifdef DNA_PACK_GC_EN
    task automatic test_gc();
        logic [1:0] d [4] = '{2'b10, 2'b00, 2'b11, 2'b01};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(d[i], 1'b0);
        checks++;
        if (bus.out_gc !== 3'd2 || bus.out_word !== 8'b10001101) begin
            failures++;
            $display("FAIL gc_full: gc=%0d word=%b expected 2 10001101", bus.out_gc, bus.out_word);
        end
        send(2'b11, 1'b1);
        checks++;
        if (bus.out_gc !== 3'd1 || bus.out_count !== 3'd1) begin
            failures++;
            $display("FAIL gc_partial: gc=%0d count=%0d expected 1 1", bus.out_gc, bus.out_count);
        end
        step();
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_full_word();
        test_partial_flush();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
`ifdef DNA_PACK_GC_EN
        test_gc();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
